// File: rtl/mmul_parallel_addressgen_pkg.sv
// Shared types and widths for the MMUL_PARALLEL streamer address generator.
// Optional macro MMUL_PARALLEL_ADDRGEN_ROLL_EN adds the feature-rewind path (see top).
package mmul_parallel_addressgen_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        ADDRGEN_IDLE = 2'd0,
        ADDRGEN_RUN  = 2'd1,
        ADDRGEN_DONE = 2'd2
    } addrgen_state_e;

    typedef struct packed {
        logic [CW-1:0] trans_size;
        logic [AW-1:0] line_stride;
        logic [CW-1:0] line_length;
        logic [AW-1:0] feat_stride;
        logic [CW-1:0] feat_length;
        logic [AW-1:0] base_addr;
        logic [CW-1:0] feat_roll;
    } addressgen_ctrl_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } addressgen_flags_t;

    // Terminal count of a down-counter; a zero length behaves like one.
    function automatic logic [CW-1:0] len_last(input logic [CW-1:0] len);
        return (len == '0) ? '0 : len - CW'(1);
    endfunction

endpackage

// File: rtl/mmul_parallel_addressgen_cnt.sv
// Nested line/feature down-counters; flags the last word of a line and of a feature.
module mmul_parallel_addrgen_cnt
    import mmul_parallel_addressgen_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [CW-1:0] i_line_length,
    input  logic [CW-1:0] i_feat_length,
    output logic          o_end_line,
    output logic          o_end_feat
);

    logic [CW-1:0] r_word_left;
    logic [CW-1:0] r_line_left;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word_left <= '0;
            r_line_left <= '0;
        end else if (i_clear) begin
            r_word_left <= '0;
            r_line_left <= '0;
        end else if (i_load) begin
            r_word_left <= len_last(i_line_length);
            r_line_left <= len_last(i_feat_length);
        end else if (i_step) begin
            if (r_word_left == '0) begin
                r_word_left <= len_last(i_line_length);
                r_line_left <= (r_line_left == '0) ? len_last(i_feat_length)
                                                   : r_line_left - CW'(1);
            end else begin
                r_word_left <= r_word_left - CW'(1);
            end
        end
    end

    assign o_end_line = (r_word_left == '0);
    assign o_end_feat = o_end_line && (r_line_left == '0);

endmodule

// File: rtl/mmul_parallel_addressgen.sv
// Streamer address generator answering the MMUL_PARALLEL control FSM.
// Define MMUL_PARALLEL_ADDRGEN_ROLL_EN to rewind feature bases every feat_roll features.
//
//   state | meaning
//   IDLE  | ready_start high, waiting for req_start
//   RUN   | issuing one address per handshake
//   DONE  | one-cycle done pulse, then back to IDLE
module mmul_parallel_addressgen
    import mmul_parallel_addressgen_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          req_start_i,
    output logic          ready_start_o,
    input  logic [CW-1:0] trans_size_i,
    input  logic [CW-1:0] line_length_i,
    input  logic [AW-1:0] line_stride_i,
    input  logic [CW-1:0] feat_length_i,
    input  logic [AW-1:0] feat_stride_i,
    input  logic [CW-1:0] feat_roll_i,
    input  logic [AW-1:0] base_addr_i,
    output logic [AW-1:0] addr_o,
    output logic          addr_valid_o,
    input  logic          addr_ready_i,
    output logic          done_o,
    output logic [CW-1:0] word_cnt_o
);

    localparam logic [1:0]    ST_IDLE   = ADDRGEN_IDLE;
    localparam logic [1:0]    ST_RUN    = ADDRGEN_RUN;
    localparam logic [1:0]    ST_DONE   = ADDRGEN_DONE;
    localparam logic [AW-1:0] WORD_STEP = AW'(DW / 8);

    addressgen_ctrl_t  w_in_ctrl;
    addressgen_ctrl_t  r_ctrl;
    addressgen_flags_t w_out_flags;

    logic [1:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_line_base;
    logic [AW-1:0] r_feat_base;
    logic [CW-1:0] r_word_cnt;
    logic          r_valid;
    logic          r_ready_start;
    logic          r_done;

    logic          w_start;
    logic          w_hs;
    logic          w_last;
    logic          w_end_line;
    logic          w_end_feat;
    logic [CW-1:0] w_line_len;
    logic [CW-1:0] w_feat_len;
    logic [AW-1:0] w_line_next;
    logic [AW-1:0] w_feat_next;

    assign w_in_ctrl = '{trans_size:  trans_size_i,
                         line_stride: line_stride_i,
                         line_length: line_length_i,
                         feat_stride: feat_stride_i,
                         feat_length: feat_length_i,
                         base_addr:   base_addr_i,
                         feat_roll:   feat_roll_i};

    assign w_start = (r_state == ST_IDLE) && req_start_i;
    assign w_hs    = r_valid && addr_ready_i;
    assign w_last  = (r_word_cnt == r_ctrl.trans_size - CW'(1));

    // The counter loads from the live inputs at start and reloads from the latched copy afterwards.
    assign w_line_len = (r_state == ST_IDLE) ? line_length_i : r_ctrl.line_length;
    assign w_feat_len = (r_state == ST_IDLE) ? feat_length_i : r_ctrl.feat_length;

    mmul_parallel_addrgen_cnt u_cnt (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_clear       (clear_i),
        .i_load        (w_start),
        .i_step        (w_hs),
        .i_line_length (w_line_len),
        .i_feat_length (w_feat_len),
        .o_end_line    (w_end_line),
        .o_end_feat    (w_end_feat)
    );

    assign w_line_next = r_line_base + r_ctrl.line_stride;

`ifdef MMUL_PARALLEL_ADDRGEN_ROLL_EN
    logic [CW-1:0] r_feat_cnt;
    logic          w_rewind;

    assign w_rewind    = (r_ctrl.feat_roll != '0) && (r_feat_cnt == r_ctrl.feat_roll - CW'(1));
    assign w_feat_next = w_rewind ? r_ctrl.base_addr : r_feat_base + r_ctrl.feat_stride;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_feat_cnt <= '0;
        end else if (clear_i || w_start) begin
            r_feat_cnt <= '0;
        end else if (w_hs && w_end_feat) begin
            r_feat_cnt <= w_rewind ? '0 : r_feat_cnt + CW'(1);
        end
    end
`else
    logic w_unused_roll;
    assign w_unused_roll = ^{r_ctrl.feat_roll, r_ctrl.base_addr};
    assign w_feat_next   = r_feat_base + r_ctrl.feat_stride;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_ctrl        <= '0;
            r_addr        <= '0;
            r_line_base   <= '0;
            r_feat_base   <= '0;
            r_word_cnt    <= '0;
            r_valid       <= 1'b0;
            r_ready_start <= 1'b1;
            r_done        <= 1'b0;
        end else if (clear_i) begin
            r_state       <= ST_IDLE;
            r_ctrl        <= '0;
            r_addr        <= '0;
            r_line_base   <= '0;
            r_feat_base   <= '0;
            r_word_cnt    <= '0;
            r_valid       <= 1'b0;
            r_ready_start <= 1'b1;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_start_i) begin
                        r_ctrl        <= w_in_ctrl;
                        r_addr        <= base_addr_i;
                        r_line_base   <= base_addr_i;
                        r_feat_base   <= base_addr_i;
                        r_word_cnt    <= '0;
                        r_ready_start <= 1'b0;
                        if (trans_size_i == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        r_word_cnt <= r_word_cnt + CW'(1);
                        if (!w_end_line) begin
                            r_addr <= r_addr + WORD_STEP;
                        end else if (!w_end_feat) begin
                            r_line_base <= w_line_next;
                            r_addr      <= w_line_next;
                        end else begin
                            r_feat_base <= w_feat_next;
                            r_line_base <= w_feat_next;
                            r_addr      <= w_feat_next;
                        end
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done        <= 1'b0;
                    r_ready_start <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_out_flags   = '{ready_start: r_ready_start, done: r_done};
    assign ready_start_o = w_out_flags.ready_start;
    assign done_o        = w_out_flags.done;
    assign addr_o        = r_addr;
    assign addr_valid_o  = r_valid;
    assign word_cnt_o    = r_word_cnt;

endmodule

// File: tb/tb_mmul_parallel_addressgen.sv
// Bench for mmul_parallel_addressgen: queue-based address model plus a per-cycle compare process.
// Honours MMUL_PARALLEL_ADDRGEN_ROLL_EN the same way the design does.
module tb_mmul_parallel_addressgen;

`ifdef MMUL_PARALLEL_ADDRGEN_ROLL_EN
    localparam bit ROLL_EN = 1'b1;
`else
    localparam bit ROLL_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        req_start_i = 1'b0;
    logic        ready_start_o;
    logic [15:0] trans_size_i = '0;
    logic [15:0] line_length_i = '0;
    logic [31:0] line_stride_i = '0;
    logic [15:0] feat_length_i = '0;
    logic [31:0] feat_stride_i = '0;
    logic [15:0] feat_roll_i = '0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] addr_o;
    logic        addr_valid_o;
    logic        addr_ready_i = 1'b0;
    logic        done_o;
    logic [15:0] word_cnt_o;

    mmul_parallel_addressgen dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .req_start_i   (req_start_i),
        .ready_start_o (ready_start_o),
        .trans_size_i  (trans_size_i),
        .line_length_i (line_length_i),
        .line_stride_i (line_stride_i),
        .feat_length_i (feat_length_i),
        .feat_stride_i (feat_stride_i),
        .feat_roll_i   (feat_roll_i),
        .base_addr_i   (base_addr_i),
        .addr_o        (addr_o),
        .addr_valid_o  (addr_valid_o),
        .addr_ready_i  (addr_ready_i),
        .done_o        (done_o),
        .word_cnt_o    (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected address list: word w sits at word (w % L) of line ((w / L) % F) of feature (w / (L*F)).
    logic [31:0] m_q[$];
    function automatic void model_fill(input logic [15:0] trans, input logic [15:0] ll_in,
                                       input logic [15:0] fl_in, input logic [15:0] roll,
                                       input logic [31:0] base, input logic [31:0] ls,
                                       input logic [31:0] fs);
        longint ll, fl;
        ll = (ll_in == 0) ? 1 : longint'(ll_in);
        fl = (fl_in == 0) ? 1 : longint'(fl_in);
        m_q.delete();
        for (longint w = 0; w < longint'(trans); w++) begin
            longint wi, li, fi, a;
            wi = w % ll;
            li = (w / ll) % fl;
            fi = w / (ll * fl);
            if (ROLL_EN && roll != 0) fi = fi % longint'(roll);
            a = longint'(base) + fi * longint'(fs) + li * longint'(ls) + wi * 4;
            m_q.push_back(a[31:0]);
        end
    endfunction

    bit          m_rs, m_valid, m_done, prev_stall;
    logic [15:0] m_wc;
    logic [31:0] prev_addr;
    logic [31:0] obs_q[$];
    int          obs_cyc[$];
    int          cyc = 0;

    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            m_rs = 1; m_valid = 0; m_done = 0; m_wc = '0; prev_stall = 0;
            m_q.delete();
        end else begin
            check("ready_start", 64'(ready_start_o), 64'(m_rs));
            check("addr_valid", 64'(addr_valid_o), 64'(m_valid));
            check("done", 64'(done_o), 64'(m_done));
            check("word_cnt", 64'(word_cnt_o), 64'(m_wc));
            if (m_valid && prev_stall) check("addr_hold", 64'(addr_o), 64'(prev_addr));
            prev_stall = m_valid && !addr_ready_i;
            prev_addr  = addr_o;
            if (clear_i) begin
                m_rs = 1; m_valid = 0; m_done = 0; m_wc = '0; prev_stall = 0;
                m_q.delete();
            end else if (m_done) begin
                m_done = 0;
                m_rs   = 1;
            end else if (m_rs) begin
                if (req_start_i) begin
                    m_rs = 0;
                    m_wc = '0;
                    model_fill(trans_size_i, line_length_i, feat_length_i, feat_roll_i,
                               base_addr_i, line_stride_i, feat_stride_i);
                    if (m_q.size() == 0) m_done = 1;
                    else m_valid = 1;
                end
            end else if (m_valid && addr_ready_i) begin
                check("addr", 64'(addr_o), 64'(m_q[0]));
                obs_q.push_back(addr_o);
                obs_cyc.push_back(cyc);
                void'(m_q.pop_front());
                m_wc++;
                if (m_q.size() == 0) begin
                    m_valid = 0;
                    m_done  = 1;
                end
            end
        end
    end

    // 0: always ready, 1: toggling, 2: random
    int rdy_mode = 0;
    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0:       addr_ready_i = 1'b1;
            1:       addr_ready_i = ~addr_ready_i;
            default: addr_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic start_xfer(input logic [15:0] trans, input logic [15:0] ll, input logic [15:0] fl,
                              input logic [15:0] roll, input logic [31:0] base,
                              input logic [31:0] ls, input logic [31:0] fs);
        @(posedge clk_i); #1;
        trans_size_i  = trans;
        line_length_i = ll;
        feat_length_i = fl;
        feat_roll_i   = roll;
        base_addr_i   = base;
        line_stride_i = ls;
        feat_stride_i = fs;
        req_start_i   = 1'b1;
        @(posedge clk_i); #1;
        req_start_i   = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!m_rs && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        if (!m_rs) begin
            total++;
            bad++;
            $display("FAIL %s: timeout got busy expected idle within 3000 cycles", nm);
        end
        @(posedge clk_i);
    endtask

    task automatic check_obs(input string nm, input logic [31:0] e[$]);
        check({nm, "_count"}, 64'(obs_q.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < obs_q.size(); i++)
            check(nm, 64'(obs_q[i]), 64'(e[i]));
    endtask

    task automatic clr_obs();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        logic [31:0] e[$];
        int n;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset_addr", 64'(addr_o), 64'h0);
        check("reset_ready_start", 64'(ready_start_o), 64'h1);

        // Basic burst, no backpressure
        rdy_mode = 0;
        clr_obs();
        start_xfer(16'd4, 16'd4, 16'd1, 16'd0, 32'h1000, 32'h0, 32'h0);
        wait_idle("basic");
        e = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        check_obs("basic_addr", e);
        if (obs_cyc.size() == 4) check("basic_no_bubble", 64'(obs_cyc[3] - obs_cyc[0]), 64'd3);

        // Line strides across features
        clr_obs();
        start_xfer(16'd6, 16'd2, 16'd3, 16'd0, 32'h0, 32'h100, 32'h0);
        wait_idle("strides");
        e = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h200, 32'h204};
        check_obs("strides_addr", e);
        if (obs_cyc.size() == 6) check("strides_no_bubble", 64'(obs_cyc[5] - obs_cyc[0]), 64'd5);

        // Backpressure with toggling ready
        rdy_mode = 1;
        clr_obs();
        start_xfer(16'd3, 16'd4, 16'd1, 16'd0, 32'h80, 32'h0, 32'h0);
        wait_idle("backpressure");
        e = '{32'h80, 32'h84, 32'h88};
        check_obs("bp_addr", e);
        check("bp_word_cnt", 64'(word_cnt_o), 64'd3);

        // Zero-length transfer
        rdy_mode = 0;
        clr_obs();
        start_xfer(16'd0, 16'd4, 16'd1, 16'd0, 32'h1234, 32'h0, 32'h0);
        wait_idle("zero");
        e = '{};
        check_obs("zero_addr", e);

        // Address wrap
        clr_obs();
        start_xfer(16'd2, 16'd4, 16'd1, 16'd0, 32'hFFFF_FFFC, 32'h0, 32'h0);
        wait_idle("wrap");
        e = '{32'hFFFF_FFFC, 32'h0000_0000};
        check_obs("wrap_addr", e);

        // Soft clear mid-transfer, then a clean restart
        clr_obs();
        start_xfer(16'd8, 16'd8, 16'd1, 16'd0, 32'h2000, 32'h0, 32'h0);
        n = 0;
        while (obs_q.size() < 2 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        #1 clear_i = 1'b1;
        @(posedge clk_i); #1 clear_i = 1'b0;
        @(negedge clk_i);
        check("abort_ready_start", 64'(ready_start_o), 64'h1);
        check("abort_partial", 64'(obs_q.size() < 8), 64'h1);
        clr_obs();
        start_xfer(16'd2, 16'd4, 16'd1, 16'd0, 32'h3000, 32'h0, 32'h0);
        wait_idle("restart");
        e = '{32'h3000, 32'h3004};
        check_obs("restart_addr", e);

        // req_start during RUN with different inputs must be ignored
        rdy_mode = 1;
        clr_obs();
        start_xfer(16'd6, 16'd2, 16'd3, 16'd0, 32'h0, 32'h100, 32'h0);
        @(posedge clk_i); #1;
        base_addr_i  = 32'h5555_0000;
        trans_size_i = 16'd1;
        req_start_i  = 1'b1;
        @(posedge clk_i); #1 req_start_i = 1'b0;
        wait_idle("restart_ignored");
        e = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h200, 32'h204};
        check_obs("ignore_start_addr", e);

        if (ROLL_EN) begin
            rdy_mode = 0;
            clr_obs();
            start_xfer(16'd4, 16'd1, 16'd1, 16'd2, 32'h0, 32'h0, 32'h40);
            wait_idle("roll");
            e = '{32'h0, 32'h40, 32'h0, 32'h40};
            check_obs("roll_addr", e);
        end

        // Randomised transfers against the model
        for (int t = 0; t < 30; t++) begin
            rdy_mode = int'($urandom_range(0, 2));
            clr_obs();
            start_xfer(16'($urandom_range(0, 24)), 16'($urandom_range(0, 5)),
                       16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                       $urandom, $urandom, $urandom);
            wait_idle("random");
        end

        repeat (3) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
